fpga_sram_req_bridge: RTL and testbench

// - Sits directly upstream of one port of the 32-bit byte-maskable dual-port FPGA SRAM.
// - Converts a valid/ready request stream (read or masked write) into SRAM port strobes.
// - Tracks the fixed SRAM read latency and buffers read data in a response FIFO so the

---
 rtl/fpga_sram_pkg.sv | 10 +
 rtl/fpga_sram_req_bridge_if.sv | 30 +++
 rtl/fpga_sram_rsp_fifo.sv | 58 +++++
 rtl/fpga_sram_req_bridge.sv | 88 ++++++++
 tb/tb_fpga_sram_req_bridge.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_sram_pkg.sv
// Shared types for the 32-bit byte-maskable FPGA SRAM and the blocks that talk to it.
package fpga_sram_pkg;

    localparam int SRAM_DATA_WIDTH   = 32;
    localparam int SRAM_WBMASK_WIDTH = 4;

    typedef logic [SRAM_DATA_WIDTH-1:0]   word_t;
    typedef logic [SRAM_WBMASK_WIDTH-1:0] wbmask_t;

endpackage

// File: rtl/fpga_sram_req_bridge_if.sv
// Request/response handshake bundle between a requester and the SRAM request bridge.
// The master side issues requests and consumes responses; the slave side is the bridge.
interface fpga_sram_req_bridge_if
    import fpga_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    word_t                 req_wdata;
    wbmask_t               req_wbmask;

    logic                  rsp_valid;
    logic                  rsp_ready;
    word_t                 rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wbmask, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wbmask, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/fpga_sram_rsp_fifo.sv
// Small register-based response FIFO. Pointers carry one extra wrap bit so that full and
// empty can be told apart without a separate occupancy counter. Push and pop may coincide
// at any occupancy; a pop on empty and a push on full without a pop are ignored.
module fpga_sram_rsp_fifo
    import fpga_sram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  word_t data_in,
    input  logic  pop,
    output word_t data_out,
    output logic  empty,
    output logic  full
);

    localparam int PTR_W = $clog2(DEPTH);

    word_t            mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign data_out = mem[rd_ptr[PTR_W-1:0]];

    // A pop frees the head slot in the same edge, so a push into a full FIFO is fine then.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Advance the read and write pointers; they wrap naturally through the extra MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: nothing is visible until the write pointer moves past it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr[PTR_W-1:0]] <= data_in;
        end
    end

endmodule

// File: rtl/fpga_sram_req_bridge.sv
// Turns a valid/ready request stream into strobes for one SRAM port and collects the read
// data, after the SRAM's fixed latency, into a response FIFO. A credit counter covering
// reads in flight plus buffered responses stops new requests before the FIFO could overflow,
// so the consumer may stall responses indefinitely without losing any.
module fpga_sram_req_bridge
    import fpga_sram_pkg::*;
#(
    parameter int  DEPTH           = 1024,
    parameter int  OUTPUT_REGISTER = 0,
    parameter int  RSP_DEPTH       = 4,
    localparam int ADDR_WIDTH      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fpga_sram_req_bridge_if.slave bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_re,
    output logic                  sram_we,
    output word_t                 sram_wdata,
    output wbmask_t               sram_wbmask,
    input  word_t                 sram_rdata
);

    localparam int               LATENCY = 1 + OUTPUT_REGISTER;
    localparam int               CNT_W   = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);

    logic               acc;
    logic               pop;
    logic               push;
    logic               fifo_empty;
    logic               fifo_full;
    word_t              fifo_head;
    logic [CNT_W-1:0]   cnt;
    logic [LATENCY-1:0] inflight;

    // Ready only looks at registered credit state, never at this cycle's pop or request type.
    assign bus.req_ready = rst_n && (cnt != CNT_MAX);
    assign acc           = bus.req_valid && bus.req_ready;

    assign sram_we     = acc && bus.req_we;
    assign sram_re     = acc && !bus.req_we;
    assign sram_addr   = bus.req_addr;
    assign sram_wdata  = bus.req_wdata;
    assign sram_wbmask = bus.req_wbmask;

    assign pop           = bus.rsp_valid && bus.rsp_ready;
    assign push          = inflight[LATENCY-1];
    assign bus.rsp_valid = !fifo_empty;
    assign bus.rsp_rdata = fifo_head;

    // Credits: one taken per accepted read, one returned per consumed response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sram_re && !pop) begin
            cnt <= cnt + 1'b1;
        end else if (!sram_re && pop) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Delay line marking which edges carry valid read data out of the SRAM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            inflight <= (inflight << 1) | LATENCY'(sram_re);
        end
    end

    fpga_sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .data_in  (sram_rdata),
        .pop      (pop),
        .data_out (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The credit scheme guarantees a push never meets a full FIFO without a matching pop.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_fpga_sram_req_bridge.sv
// Bench for the SRAM request bridge. Two lanes run the same request sequence side by side:
// lane 0 with OUTPUT_REGISTER = 0 and lane 1 with OUTPUT_REGISTER = 1, each with its own
// behavioural SRAM. Expected read data comes from a word-level memory model and is queued
// per lane when a request is issued; a monitor pops and compares on every response handshake.
module tb_fpga_sram_req_bridge;
    import fpga_sram_pkg::*;

    localparam int DEPTH     = 1024;
    localparam int AW        = 10;
    localparam int RSP_DEPTH = 4;
    localparam int NLANES    = 2;
    localparam int NWORDS    = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NLANES-1:0] req_valid_v;
    logic              req_we;
    logic [AW-1:0]     req_addr;
    word_t             req_wdata;
    wbmask_t           req_wbmask;
    logic              rsp_ready;
    logic              rand_ready_en = 1'b0;

    logic [NLANES-1:0] lane_req_ready;
    logic [NLANES-1:0] lane_rsp_valid;
    logic [NLANES-1:0] lane_sram_re;
    logic [NLANES-1:0] lane_sram_we;
    word_t             lane_rsp_rdata [NLANES];

    word_t             exp_q [NLANES][$];
    word_t             ref_mem [NWORDS];
    int                n_vectors     = 0;
    int                n_miscompares = 0;

    for (genvar g = 0; g < NLANES; g++) begin : lane
        fpga_sram_req_bridge_if #(.ADDR_WIDTH(AW)) bus ();

        logic [AW-1:0] sram_addr;
        logic          sram_re;
        logic          sram_we;
        word_t         sram_wdata;
        wbmask_t       sram_wbmask;
        word_t         sram_rdata;
        word_t         rd_stage;
        word_t         rd_out;
        word_t         mem [DEPTH];

        assign bus.req_valid  = req_valid_v[g];
        assign bus.req_we     = req_we;
        assign bus.req_addr   = req_addr;
        assign bus.req_wdata  = req_wdata;
        assign bus.req_wbmask = req_wbmask;
        assign bus.rsp_ready  = rsp_ready;

        assign lane_req_ready[g] = bus.req_ready;
        assign lane_rsp_valid[g] = bus.rsp_valid;
        assign lane_rsp_rdata[g] = bus.rsp_rdata;
        assign lane_sram_re[g]   = sram_re;
        assign lane_sram_we[g]   = sram_we;

        fpga_sram_req_bridge #(
            .DEPTH           (DEPTH),
            .OUTPUT_REGISTER (g),
            .RSP_DEPTH       (RSP_DEPTH)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .bus         (bus),
            .sram_addr   (sram_addr),
            .sram_re     (sram_re),
            .sram_we     (sram_we),
            .sram_wdata  (sram_wdata),
            .sram_wbmask (sram_wbmask),
            .sram_rdata  (sram_rdata)
        );

        // SRAM port: byte-masked write, old-data read, optional output register.
        always @(posedge clk) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wbmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end
            if (sram_re) rd_stage <= mem[sram_addr];
            rd_out <= rd_stage;
        end

        assign sram_rdata = (g == 0) ? rd_stage : rd_out;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Response monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        word_t exp_word;
        if (rst_n === 1'b1) begin
            for (int g = 0; g < NLANES; g++) begin
                if (lane_rsp_valid[g] && rsp_ready) begin
                    if (exp_q[g].size() == 0) begin
                        checkOutput($sformatf("unexpected_rsp_lane%0d", g), 32'd1, 32'd0);
                    end else begin
                        exp_word = exp_q[g].pop_front();
                        checkOutput($sformatf("rsp_rdata_lane%0d", g), lane_rsp_rdata[g], exp_word);
                    end
                end
            end
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rand_ready_en) begin
            #2;
            rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    // Issue one request to both lanes; each lane drops valid once it has accepted.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input word_t wdata,
                                 input wbmask_t mask, output int cycles);
        logic [NLANES-1:0] taking;
        word_t             bits;
        bits = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        if (we) begin
            ref_mem[addr[5:0]] = (ref_mem[addr[5:0]] & ~bits) | (wdata & bits);
        end else begin
            for (int g = 0; g < NLANES; g++) exp_q[g].push_back(ref_mem[addr[5:0]]);
        end
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wdata;
        req_wbmask  = mask;
        req_valid_v = '1;
        cycles      = 0;
        while (req_valid_v != '0 && cycles < 100) begin
            taking = req_valid_v & lane_req_ready;
            @(posedge clk);
            #1;
            req_valid_v = req_valid_v & ~taking;
            cycles++;
        end
        checkOutput("accept_timeout", 32'(req_valid_v), 32'd0);
        req_valid_v = '0;
    endtask

    // Hold reset (driving a read the whole time) and check the idle state after release.
    task automatic applyReset(input int n);
        rst_n       = 1'b0;
        req_valid_v = '1;
        req_we      = 1'b0;
        req_addr    = '0;
        for (int g = 0; g < NLANES; g++) exp_q[g].delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("reset_req_ready", 32'(lane_req_ready), 32'd0);
            checkOutput("reset_sram_strobes", 32'({lane_sram_re, lane_sram_we}), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid_v = '0;
        rst_n       = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_rsp_valid", 32'(lane_rsp_valid), 32'd0);
        checkOutput("post_reset_req_ready", 32'(lane_req_ready), 32'({NLANES{1'b1}}));
        @(posedge clk);
        #1;
    endtask

    // Measure, per lane, the cycle in which rsp_valid first rises after an accept.
    task automatic checkLatency(input word_t expected_word);
        int first_seen [NLANES];
        for (int g = 0; g < NLANES; g++) first_seen[g] = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int g = 0; g < NLANES; g++) begin
                if (first_seen[g] == 0 && lane_rsp_valid[g]) begin
                    first_seen[g] = k;
                    checkOutput($sformatf("first_rdata_lane%0d", g), lane_rsp_rdata[g], expected_word);
                end
            end
        end
        for (int g = 0; g < NLANES; g++) begin
            checkOutput($sformatf("latency_lane%0d", g), 32'(first_seen[g]), 32'(g + 2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int waited = 0;
        rand_ready_en = 1'b0;
        @(posedge clk);
        #3;
        rsp_ready = 1'b1;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && waited < 200) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drain_leftover", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int total;
        rst_n       = 1'b0;
        req_valid_v = '0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_wbmask  = '0;
        rsp_ready   = 1'b0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;

        applyReset(3);

        // Give every word used below a known random value.
        rsp_ready = 1'b1;
        for (int a = 0; a < NWORDS; a++) applyStimulus(1'b1, AW'(a), $urandom, 4'hF, cyc);

        $display("[TB] full-mask write then read, latency");
        applyStimulus(1'b1, AW'(16), 32'hDEADBEEF, 4'hF, cyc);
        applyStimulus(1'b0, AW'(16), 32'h0, 4'h0, cyc);
        checkLatency(32'hDEADBEEF);

        $display("[TB] partial-mask overwrite, read-after-write on consecutive cycles");
        applyStimulus(1'b1, AW'(32), 32'h11223344, 4'hF, cyc);
        applyStimulus(1'b1, AW'(32), 32'hAABBCCDD, 4'b0101, cyc);
        applyStimulus(1'b0, AW'(32), 32'h0, 4'h0, cyc);
        checkLatency(32'h11BB33DD);
        drain();

        $display("[TB] backpressure: six reads with responses stalled");
        rsp_ready = 1'b0;
        fork
            begin
                for (int a = 0; a < 6; a++) begin
                    applyStimulus(1'b0, AW'(a), 32'h0, 4'h0, cyc);
                    if (a == 3) checkOutput("ready_after_4th", 32'(lane_req_ready), 32'd0);
                end
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] streaming 64 reads");
        total = 0;
        for (int a = 0; a < NWORDS; a++) begin
            applyStimulus(1'b0, AW'(a), 32'h0, 4'h0, cyc);
            total += cyc;
        end
        checkOutput("stream_cycles", 32'(total), 32'(NWORDS));
        drain();

        $display("[TB] reset with reads outstanding");
        rsp_ready = 1'b0;
        applyStimulus(1'b0, AW'(5), 32'h0, 4'h0, cyc);
        applyStimulus(1'b0, AW'(6), 32'h0, 4'h0, cyc);
        applyReset(2);
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("no_stale_rsp", 32'(lane_rsp_valid), 32'd0);

        $display("[TB] random traffic with random backpressure");
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 2) == 0), AW'($urandom_range(0, NWORDS - 1)),
                          $urandom, 4'($urandom), cyc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
